// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM pipeline hazard controller: forward selects, FSM states
// and the shadow-pipeline slot payload.
package arm_pipe_pkg;

  localparam int unsigned REG_W = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_REG = 2'd0;
  localparam logic [SEL_W-1:0] SEL_MEM = 2'd1;
  localparam logic [SEL_W-1:0] SEL_WB  = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_r_en;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/hazard_match.sv
// Combinational comparator: does one shadow slot produce the register a source reads?
module hazard_match
  import arm_pipe_pkg::*;
(
  input  slot_t            slot,
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  output logic             hit,
  output logic             hit_load
);

  assign hit      = slot.valid & slot.wb_en & (slot.dest == src) & use_src;
  assign hit_load = hit & slot.mem_r_en;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller beside the ID/EXE register: forwarding selects, load-use stall and
// branch flush. Define PIPE_FORWARDING_EN to enable forwarding; otherwise RAW hazards stall.
module pipe_hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             exe_branch_taken,
  output logic             stall,
  output logic             flush,
  output logic [SEL_W-1:0] sel_src1,
  output logic [SEL_W-1:0] sel_src2,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipe_state_e      state_q, state_d;
  slot_t            exe_q, exe_d, mem_q, wb_q, id_slot_c;
  logic [SEL_W-1:0] sel_src1_q, sel_src1_d, sel_src2_q, sel_src2_d;
  logic [SEL_W-1:0] fwd1_c, fwd2_c;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             use1_c, use2_c, hazard_c, bubble_c;
  logic             exe_hit1, exe_hit2, exe_ld1, exe_ld2;
  logic             mem_hit1, mem_hit2, mem_ld1, mem_ld2;
  logic             unused_c;

  assign use1_c    = id_valid & id_use_src1;
  assign use2_c    = id_valid & id_use_src2;
  assign id_slot_c = '{valid: 1'b1, dest: id_dest, wb_en: id_wb_en, mem_r_en: id_mem_r_en};

  hazard_match u_exe_s1 (.slot(exe_q), .src(id_src1), .use_src(use1_c), .hit(exe_hit1), .hit_load(exe_ld1));
  hazard_match u_exe_s2 (.slot(exe_q), .src(id_src2), .use_src(use2_c), .hit(exe_hit2), .hit_load(exe_ld2));
  hazard_match u_mem_s1 (.slot(mem_q), .src(id_src1), .use_src(use1_c), .hit(mem_hit1), .hit_load(mem_ld1));
  hazard_match u_mem_s2 (.slot(mem_q), .src(id_src2), .use_src(use2_c), .hit(mem_hit2), .hit_load(mem_ld2));

  // WB results reach ID through the negedge regfile write, so the WB slot never forwards.
`ifdef PIPE_FORWARDING_EN
  assign unused_c = ^{wb_q, mem_ld1, mem_ld2};
`else
  assign unused_c = ^{wb_q, mem_ld1, mem_ld2, exe_ld1, exe_ld2};
`endif

  // Hazard detection and forward-select choice (youngest producer wins)
  always_comb begin
    hazard_c = 1'b0;
    fwd1_c   = SEL_REG;
    fwd2_c   = SEL_REG;
`ifdef PIPE_FORWARDING_EN
    hazard_c = exe_ld1 | exe_ld2;
    fwd1_c   = exe_hit1 ? SEL_MEM : (mem_hit1 ? SEL_WB : SEL_REG);
    fwd2_c   = exe_hit2 ? SEL_MEM : (mem_hit2 ? SEL_WB : SEL_REG);
`else
    hazard_c = exe_hit1 | exe_hit2 | mem_hit1 | mem_hit2;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (exe_branch_taken) state_d = ST_FLUSH;
                else if (hazard_c)    state_d = ST_STALL;
      ST_STALL: if (exe_branch_taken) state_d = ST_FLUSH;
                else if (!hazard_c)   state_d = ST_RUN;
      ST_FLUSH: state_d = exe_branch_taken ? ST_FLUSH : ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Outputs: a taken branch overrides any stall and drops the stalled ID instruction
  always_comb begin
    flush = exe_branch_taken;
    stall = hazard_c & ~exe_branch_taken;
  end

  // Shadow pipeline, registered selects and saturating counters
  always_comb begin
    bubble_c    = stall | flush | ~id_valid;
    exe_d       = bubble_c ? SLOT_BUBBLE : id_slot_c;
    sel_src1_d  = bubble_c ? SEL_REG : fwd1_c;
    sel_src2_d  = bubble_c ? SEL_REG : fwd2_c;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_q       <= SLOT_BUBBLE;
      mem_q       <= SLOT_BUBBLE;
      wb_q        <= SLOT_BUBBLE;
      sel_src1_q  <= SEL_REG;
      sel_src2_q  <= SEL_REG;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      exe_q       <= exe_d;
      mem_q       <= exe_q;
      wb_q        <= mem_q;
      sel_src1_q  <= sel_src1_d;
      sel_src2_q  <= sel_src2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign sel_src1  = sel_src1_q;
  assign sel_src2  = sel_src2_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed ARM sequences plus random traffic
// against an instruction-history model of the pipeline.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_src1, id_use_src2, id_wb_en, id_mem_r_en, exe_branch_taken;
  logic [3:0] id_src1, id_src2, id_dest;
  logic       stall, flush;
  logic [1:0] sel_src1, sel_src2;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .exe_branch_taken(exe_branch_taken),
    .stall(stall), .flush(flush), .sel_src1(sel_src1), .sel_src2(sel_src2),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {bit v; int d; bit wb; bit ld;} ent_t;
  typedef struct {bit v; int s1; bit u1; int s2; bit u2; int d; bit wb; bit ld;} ins_t;

  // hist[0] = instruction now in EXE, hist[1] = MEM, hist[2] = WB
  ent_t hist[3];
  int   m_sel1, m_sel2, m_scnt, m_fcnt;
  bit   m_stall_prev, m_flush_prev;
  bit   obs_stall, obs_flush;
  int   n_cmp = 0, n_bad = 0;

  function automatic ins_t mk(bit v, int s1, bit u1, int s2, bit u2, int d, bit wb, bit ld);
    ins_t r;
    r.v = v; r.s1 = s1; r.u1 = u1; r.s2 = s2; r.u2 = u2; r.d = d; r.wb = wb; r.ld = ld;
    return r;
  endfunction

  // How many stages ahead the youngest in-flight producer of s sits (3 = none)
  function automatic int producer_age(int s, bit used);
    if (!used) return 3;
    for (int k = 0; k < 3; k++)
      if (hist[k].v && hist[k].wb && hist[k].d == s) return k;
    return 3;
  endfunction

  function automatic bit src_hazard(int s, bit used);
    int a;
    a = producer_age(s, used);
`ifdef PIPE_FORWARDING_EN
    return (a == 0) && hist[0].ld;
`else
    return a <= 1;
`endif
  endfunction

  function automatic int src_sel(int s, bit used);
    int a;
    a = producer_age(s, used);
`ifdef PIPE_FORWARDING_EN
    if (a == 0) return 1;
    if (a == 1) return 2;
`endif
    return 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0};
    m_sel1 = 0; m_sel2 = 0; m_scnt = 0; m_fcnt = 0;
    m_stall_prev = 0; m_flush_prev = 0;
  endtask

  task automatic drive_idle();
    id_valid = 0; id_src1 = 0; id_src2 = 0; id_use_src1 = 0; id_use_src2 = 0;
    id_dest = 0; id_wb_en = 0; id_mem_r_en = 0; exe_branch_taken = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    drive_idle();
    model_reset();
    #3;
    @(negedge clk);
    rst_n = 1;
  endtask

  // One pipeline cycle: check registered state, present ID/branch, check stall/flush, advance model
  task automatic cycle(input ins_t i, input bit br);
    bit hz, es, ef, bub;
    @(negedge clk);
    chk("sel_src1", int'(sel_src1), m_sel1);
    chk("sel_src2", int'(sel_src2), m_sel2);
    chk("stall_cnt", int'(stall_cnt), m_scnt);
    chk("flush_cnt", int'(flush_cnt), m_fcnt);
    id_valid = i.v; id_src1 = 4'(i.s1); id_src2 = 4'(i.s2);
    id_use_src1 = i.u1; id_use_src2 = i.u2; id_dest = 4'(i.d);
    id_wb_en = i.wb; id_mem_r_en = i.ld; exe_branch_taken = br;
    #1;
    hz = i.v && (src_hazard(i.s1, i.u1) || src_hazard(i.s2, i.u2));
    es = hz && !br;
    ef = br;
    chk("stall", int'(stall), int'(es));
    chk("flush", int'(flush), int'(ef));
    obs_stall = stall;
    obs_flush = flush;
    bub = !i.v || es || ef;
    m_sel1 = bub ? 0 : src_sel(i.s1, i.v && i.u1);
    m_sel2 = bub ? 0 : src_sel(i.s2, i.v && i.u2);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = bub ? '{0, 0, 0, 0} : '{1, i.d, i.wb, i.ld};
    if (es && m_scnt < CNT_MAX) m_scnt++;
    if (ef && m_fcnt < CNT_MAX) m_fcnt++;
    m_stall_prev = es;
    m_flush_prev = ef;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    ins_t nop, add1, sub2, orr4, ldr1, addi2, cur;
    bit   br;
    nop   = mk(0, 0, 0, 0, 0, 0, 0, 0);
    add1  = mk(1, 5, 1, 6, 1, 1, 1, 0);  // ADD r1,r5,r6
    sub2  = mk(1, 1, 1, 3, 1, 2, 1, 0);  // SUB r2,r1,r3
    orr4  = mk(1, 5, 1, 1, 1, 4, 1, 0);  // ORR r4,r5,r1
    ldr1  = mk(1, 7, 1, 0, 0, 1, 1, 1);  // LDR r1,[r7]
    addi2 = mk(1, 1, 1, 0, 0, 2, 1, 0);  // ADD r2,r1,#4

    rst_n = 0;
    drive_idle();
    model_reset();
    #2;
    chk("rst_stall", int'(stall), 0);
    chk("rst_flush", int'(flush), 0);
    chk("rst_sel1", int'(sel_src1), 0);
    chk("rst_sel2", int'(sel_src2), 0);
    chk("rst_scnt", int'(stall_cnt), 0);
    chk("rst_fcnt", int'(flush_cnt), 0);
    @(negedge clk);
    rst_n = 1;

`ifdef PIPE_FORWARDING_EN
    // ADD r1 ; SUB r2,r1,r3 -> EXE-to-EXE forward, no stall
    cycle(add1, 0);
    cycle(sub2, 0);
    chk("t1_stall", int'(obs_stall), 0);
    @(posedge clk); #1;
    chk("t1_sel1", int'(sel_src1), 1);
    cycle(nop, 0);

    // ADD r1 ; NOP ; ORR r4,r5,r1 -> WB-value forward on src2
    do_reset();
    cycle(add1, 0);
    cycle(nop, 0);
    cycle(orr4, 0);
    @(posedge clk); #1;
    chk("t2_sel2", int'(sel_src2), 2);
    chk("t2_sel1", int'(sel_src1), 0);

    // LDR r1 ; ADD r2,r1,#4 -> one stall then forward from WB value
    do_reset();
    cycle(ldr1, 0);
    cycle(addi2, 0);
    chk("t3_stall1", int'(obs_stall), 1);
    cycle(addi2, 0);
    chk("t3_stall2", int'(obs_stall), 0);
    @(posedge clk); #1;
    chk("t3_sel1", int'(sel_src1), 2);
    chk("t3_scnt", int'(stall_cnt), 1);
`else
    // ADD r1 ; SUB r2,r1,r3 without forwarding -> two stall cycles
    cycle(add1, 0);
    cycle(sub2, 0);
    chk("t5_stall1", int'(obs_stall), 1);
    cycle(sub2, 0);
    chk("t5_stall2", int'(obs_stall), 1);
    cycle(sub2, 0);
    chk("t5_stall3", int'(obs_stall), 0);
    @(posedge clk); #1;
    chk("t5_scnt", int'(stall_cnt), 2);
    chk("t5_sel1", int'(sel_src1), 0);
`endif

    // Taken branch while load-use pending -> flush wins, bubble enters EXE
    do_reset();
    cycle(ldr1, 0);
    cycle(addi2, 1);
    chk("t4_flush", int'(obs_flush), 1);
    chk("t4_stall", int'(obs_stall), 0);
    @(posedge clk); #1;
    chk("t4_fcnt", int'(flush_cnt), 1);
    chk("t4_scnt", int'(stall_cnt), 0);
    chk("t4_sel1", int'(sel_src1), 0);
    cycle(nop, 0);

    // Reset asserted in the middle of a stall
    do_reset();
    cycle(ldr1, 0);
    cycle(addi2, 0);
    cycle(addi2, 0);
    cycle(addi2, 0);
    cycle(ldr1, 0);
    cycle(addi2, 0);
    chk("t6_stall_pre", int'(obs_stall), 1);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("t6_stall", int'(stall), 0);
    chk("t6_sel1", int'(sel_src1), 0);
    chk("t6_scnt", int'(stall_cnt), 0);
    chk("t6_fcnt", int'(flush_cnt), 0);
    drive_idle();
    @(negedge clk);
    rst_n = 1;

    // Random traffic; ID holds a stalled instruction and is empty after a flush
    cur = nop;
    for (int n = 0; n < 3000; n++) begin
      if (!m_stall_prev) begin
        cur = mk(($urandom % 5) != 0, int'($urandom % 4), $urandom % 2 == 0,
                 int'($urandom % 4), $urandom % 2 == 0, int'($urandom % 4),
                 ($urandom % 4) != 0, ($urandom % 3) == 0);
        if (m_flush_prev) cur.v = 0;
      end
      br = ($urandom % 10) == 0;
      cycle(cur, br);
    end
    @(negedge clk);
    chk("end_scnt", int'(stall_cnt), m_scnt);
    chk("end_fcnt", int'(flush_cnt), m_fcnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
